// File: rtl/seq_detect_mealy_pkg.sv
// Shared types and elaboration-time helpers for the overlapping serial pattern detector.
// The pattern is read MSB-first: PATTERN[LEN-1] is the first bit received.
package seq_det_pkg;

   localparam int unsigned PAT_MAX   = 16;
   localparam int unsigned LEN_DEF   = 4;
   localparam int unsigned CNT_W_DEF = 8;

   function automatic int unsigned st_width(input int len);
      return int'($clog2(len)) + 1;
   endfunction

   localparam int unsigned ST_W = st_width(LEN_DEF);

   // Bit i of the pattern in arrival order (i = 0 is the first bit received).
   function automatic logic pat_bit(input logic [PAT_MAX-1:0] pattern, input int len,
                                    input int i);
      return pattern[4'(len - 1 - i)];
   endfunction

   // Longest proper prefix of the pattern that is also a suffix of
   // (first k pattern bits followed by b); k+1 == len yields the overlap restart point.
   function automatic int next_state(input int k, input logic b,
                                     input logic [PAT_MAX-1:0] pattern, input int len);
      int   best;
      int   j;
      logic ok;
      logic sb;
      best = 0;
      for (int f = 1; f < PAT_MAX; f++) begin
         if (f < len && f <= k + 1) begin
            ok = 1'b1;
            for (int i = 0; i < PAT_MAX; i++) begin
               if (i < f) begin
                  j  = k + 1 - f + i;
                  sb = (j == k) ? b : pat_bit(pattern, len, j);
                  if (pat_bit(pattern, len, i) != sb) ok = 1'b0;
               end
            end
            if (ok) best = f;
         end
      end
      return best;
   endfunction

   // Longest proper prefix of the pattern that is also a suffix of it.
   function automatic int border_len(input logic [PAT_MAX-1:0] pattern, input int len);
      int   best;
      logic ok;
      best = 0;
      for (int f = 1; f < PAT_MAX; f++) begin
         if (f < len) begin
            ok = 1'b1;
            for (int i = 0; i < PAT_MAX; i++) begin
               if (i < f && pat_bit(pattern, len, i) != pat_bit(pattern, len, len - f + i))
                  ok = 1'b0;
            end
            if (ok) best = f;
         end
      end
      return best;
   endfunction

endpackage

// File: rtl/seq_detect_mealy_if.sv
// Button-side inputs and detector outputs of seq_detect_mealy, bundled for port hookup.
interface seq_detect_mealy_if
   import seq_det_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF,
   parameter int unsigned SW    = ST_W
);
   logic             input_pulse;
   logic             input_1;
   logic             bit_valid;
   logic             bit_value;
   logic             detect;
   logic             detect_led;
   logic [CNT_W-1:0] match_count;
   logic [SW-1:0]    state;

   modport master (
      output input_pulse, input_1,
      input  bit_valid, bit_value, detect, detect_led, match_count, state
   );

   modport slave (
      input  input_pulse, input_1,
      output bit_valid, bit_value, detect, detect_led, match_count, state
   );
endinterface

// File: rtl/seq_detect_mealy_pulse_rise_det.sv
// Rising-edge detector on a registered button level; shared by the button stages.
module pulse_rise_det (
   input  logic clk_1H,
   input  logic rst,
   input  logic d,
   output logic rise
);
   logic pulse_q;
   logic pulse_d;

   always_comb pulse_d = d;

   always_ff @(posedge clk_1H or posedge rst) begin
      if (rst) pulse_q <= 1'b0;
      else     pulse_q <= pulse_d;
   end

   // Forced low during reset so a held button cannot strobe before release.
   assign rise = d & ~pulse_q & ~rst;
endmodule

// File: rtl/seq_detect_mealy.sv
// Overlapping Mealy detector: one serial bit per new press, KMP-style fallback on mismatch,
// detect strobe plus held LED flag and saturating match counter.
module seq_detect_mealy
   import seq_det_pkg::*;
#(
   parameter int unsigned     LEN     = LEN_DEF,
   parameter logic [LEN-1:0]  PATTERN = 4'b1011,
   parameter int unsigned     CNT_W   = CNT_W_DEF
) (
   input  logic               clk_1H,
   input  logic               rst,
   seq_detect_mealy_if.slave  bus
);
   localparam int unsigned SW     = st_width(LEN);
   localparam int unsigned TBL_N  = 2 ** (SW + 1);
   localparam int unsigned BORDER = border_len(PAT_MAX'(PATTERN), LEN);

   logic             bit_valid_c;
   logic             detect_c;
   logic             bit_q, bit_d;
   logic [SW-1:0]    state_q, state_d;
   logic             led_q, led_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SW-1:0]    ns_tbl [TBL_N];

   pulse_rise_det u_rise (
      .clk_1H (clk_1H),
      .rst    (rst),
      .d      (bus.input_pulse),
      .rise   (bit_valid_c)
   );

   // Constant transition table indexed by {state, bit}; entries past S(LEN-1) are unreachable.
   for (genvar idx = 0; idx < TBL_N; idx++) begin : g_tbl
      if ((idx / 2) < LEN) begin : g_live
         localparam int NS = next_state(idx / 2, 1'(idx % 2), PAT_MAX'(PATTERN), LEN);
         assign ns_tbl[idx] = SW'(NS);
      end else begin : g_dead
         assign ns_tbl[idx] = '0;
      end
   end

   always_comb begin
      bit_d    = bus.input_1;
      state_d  = state_q;
      led_d    = led_q;
      cnt_d    = cnt_q;
      detect_c = 1'b0;
      if (bit_valid_c) begin
         if (state_q == SW'(LEN - 1) && bit_q == PATTERN[0]) begin
            detect_c = 1'b1;
            state_d  = SW'(BORDER);
         end else begin
            state_d  = ns_tbl[{state_q, bit_q}];
         end
         led_d = detect_c;
         if (detect_c && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_1H or posedge rst) begin
      if (rst) begin
         bit_q   <= 1'b0;
         state_q <= '0;
         led_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         bit_q   <= bit_d;
         state_q <= state_d;
         led_q   <= led_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.bit_valid   = bit_valid_c;
   assign bus.bit_value   = bit_q;
   assign bus.detect      = detect_c;
   assign bus.detect_led  = led_q;
   assign bus.match_count = cnt_q;
   assign bus.state       = state_q;
endmodule

// File: tb/tb_seq_detect_mealy.sv
// Bench for seq_detect_mealy: two instances (CNT_W=8 and CNT_W=2) share the button stimulus
// and are compared every clock against a bit-history reference model.
module tb_seq_detect_mealy;
   localparam int          LEN = 4;
   localparam logic [3:0]  PAT = 4'b1011;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ip  = 1'b0;
   logic i1  = 1'b0;

   int vectors = 0;
   int errors  = 0;

   // Reference model state.
   bit   hist[$];
   logic m_prev_pulse = 1'b0;
   logic m_prev_i1    = 1'b0;
   logic m_led        = 1'b0;
   int   m_cnt        = 0;
   int   m_cnt2       = 0;

   // Per-scenario observations taken from DUT A.
   int          nv       = 0;
   int          det_cnt  = 0;
   logic [31:0] det_mask = '0;
   logic        last_val = 1'b0;

   seq_detect_mealy_if #(.CNT_W(8), .SW(3)) if_a ();
   seq_detect_mealy_if #(.CNT_W(2), .SW(3)) if_b ();

   assign if_a.input_pulse = ip;
   assign if_a.input_1     = i1;
   assign if_b.input_pulse = ip;
   assign if_b.input_1     = i1;

   seq_detect_mealy #(.LEN(4), .PATTERN(4'b1011), .CNT_W(8)) u_dut_a (
      .clk_1H (clk), .rst (rst), .bus (if_a.slave));
   seq_detect_mealy #(.LEN(4), .PATTERN(4'b1011), .CNT_W(2)) u_dut_b (
      .clk_1H (clk), .rst (rst), .bus (if_b.slave));

   always #5 clk = ~clk;

   // True when the newest f bits of the history equal the first f bits of the pattern.
   function automatic bit tail_is_prefix(int f);
      int n = hist.size();
      if (f > n) return 1'b0;
      for (int i = 0; i < f; i++)
         if (hist[n - f + i] != PAT[LEN - 1 - i]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int exp_state();
      for (int f = LEN - 1; f > 0; f--)
         if (tail_is_prefix(f)) return f;
      return 0;
   endfunction

   task automatic clear_obs();
      nv = 0; det_cnt = 0; det_mask = '0; last_val = 1'b0;
   endtask

   task automatic do_reset(input logic p, input logic b);
      @(negedge clk);
      rst = 1'b1; ip = p; i1 = b;
      #1;
      vectors++;
      if (if_a.bit_valid !== 1'b0 || if_b.bit_valid !== 1'b0) begin
         errors++; $display("FAIL reset_bit_valid: got %b/%b want 0", if_a.bit_valid, if_b.bit_valid);
      end
      vectors++;
      if (if_a.detect !== 1'b0 || if_b.detect !== 1'b0) begin
         errors++; $display("FAIL reset_detect: got %b/%b want 0", if_a.detect, if_b.detect);
      end
      vectors++;
      if (if_a.state !== 3'd0 || if_a.detect_led !== 1'b0 || if_a.match_count !== 8'd0) begin
         errors++;
         $display("FAIL reset_regs: got state=%0d led=%b cnt=%0d want 0/0/0",
                  if_a.state, if_a.detect_led, if_a.match_count);
      end
      vectors++;
      if (if_b.state !== 3'd0 || if_b.detect_led !== 1'b0 || if_b.match_count !== 2'd0) begin
         errors++;
         $display("FAIL reset_regs_b: got state=%0d led=%b cnt=%0d want 0/0/0",
                  if_b.state, if_b.detect_led, if_b.match_count);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      hist.delete();
      m_prev_pulse = 1'b0; m_prev_i1 = 1'b0; m_led = 1'b0; m_cnt = 0; m_cnt2 = 0;
   endtask

   // One clock: drive inputs, check combinational outputs, then registered outputs after the edge.
   task automatic step(input logic p, input logic b);
      logic ev, ev_val, ed;
      int   es;
      @(negedge clk);
      ip = p; i1 = b;
      #1;
      ev     = p && !m_prev_pulse;
      ev_val = m_prev_i1;
      ed     = 1'b0;
      if (ev) begin
         hist.push_back(ev_val);
         ed = tail_is_prefix(LEN);
      end
      vectors++;
      if (if_a.bit_valid !== ev || if_b.bit_valid !== ev) begin
         errors++; $display("FAIL bit_valid: got %b/%b want %b", if_a.bit_valid, if_b.bit_valid, ev);
      end
      if (ev) begin
         vectors++;
         if (if_a.bit_value !== ev_val) begin
            errors++; $display("FAIL bit_value: got %b want %b", if_a.bit_value, ev_val);
         end
      end
      vectors++;
      if (if_a.detect !== ed || if_b.detect !== ed) begin
         errors++; $display("FAIL detect: got %b/%b want %b", if_a.detect, if_b.detect, ed);
      end
      if (if_a.bit_valid === 1'b1) begin
         if (if_a.detect === 1'b1) begin
            det_cnt++;
            if (nv < 32) det_mask[nv] = 1'b1;
         end
         last_val = if_a.bit_value;
         nv++;
      end
      @(posedge clk);
      #1;
      if (ev) begin
         m_led = ed;
         if (ed) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt2 < 3)  m_cnt2++;
         end
      end
      m_prev_pulse = p;
      m_prev_i1    = b;
      while (hist.size() > 32) void'(hist.pop_front());
      es = exp_state();
      vectors++;
      if (if_a.state !== 3'(es) || if_b.state !== 3'(es)) begin
         errors++; $display("FAIL state: got %0d/%0d want %0d", if_a.state, if_b.state, es);
      end
      vectors++;
      if (if_a.detect_led !== m_led || if_b.detect_led !== m_led) begin
         errors++;
         $display("FAIL detect_led: got %b/%b want %b", if_a.detect_led, if_b.detect_led, m_led);
      end
      vectors++;
      if (if_a.match_count !== 8'(m_cnt)) begin
         errors++; $display("FAIL match_count: got %0d want %0d", if_a.match_count, m_cnt);
      end
      vectors++;
      if (if_b.match_count !== 2'(m_cnt2)) begin
         errors++; $display("FAIL match_count_sat: got %0d want %0d", if_b.match_count, m_cnt2);
      end
   endtask

   // Upstream style press: input_1 leads input_pulse by one clock, then both released.
   task automatic press(input logic b, input int hold, input int gap);
      step(1'b0, b);
      repeat (hold) step(1'b1, b);
      repeat (gap) step(1'b0, 1'b0);
   endtask

   task automatic test_reset();
      do_reset(1'b0, 1'b0);
      clear_obs();
      repeat (3) step(1'b0, 1'b0);
   endtask

   task automatic test_overlap();
      logic [6:0] seq = 7'b1011011;
      do_reset(1'b0, 1'b0);
      clear_obs();
      for (int i = 6; i >= 0; i--) press(seq[i], 3, 2);
      vectors++;
      if (det_mask !== 32'h48) begin
         errors++; $display("FAIL overlap_detect_mask: got %h want 00000048", det_mask);
      end
      vectors++;
      if (if_a.match_count !== 8'd2 || if_a.state !== 3'd1) begin
         errors++;
         $display("FAIL overlap_final: got cnt=%0d state=%0d want 2/1", if_a.match_count, if_a.state);
      end
   endtask

   task automatic test_fallback();
      logic [5:0] seq = 6'b101011;
      do_reset(1'b0, 1'b0);
      clear_obs();
      for (int i = 5; i >= 0; i--) begin
         press(seq[i], 3, 2);
         if (i == 2) begin
            vectors++;
            if (if_a.state !== 3'd2) begin
               errors++; $display("FAIL fallback_state: got %0d want 2", if_a.state);
            end
         end
      end
      vectors++;
      if (det_mask !== 32'h20 || if_a.match_count !== 8'd1) begin
         errors++;
         $display("FAIL fallback_detect: got mask=%h cnt=%0d want 00000020/1", det_mask, if_a.match_count);
      end
   endtask

   task automatic test_hold();
      do_reset(1'b0, 1'b0);
      clear_obs();
      press(1'b1, 10, 2);
      vectors++;
      if (nv !== 1 || last_val !== 1'b1) begin
         errors++; $display("FAIL hold_single_bit: got count=%0d value=%b want 1/1", nv, last_val);
      end
   endtask

   task automatic test_reset_mid();
      logic [2:0] seq = 3'b101;
      do_reset(1'b0, 1'b0);
      clear_obs();
      for (int i = 2; i >= 0; i--) press(seq[i], 3, 2);
      do_reset(1'b0, 1'b0);
      press(1'b1, 3, 2);
      vectors++;
      if (det_cnt !== 0 || if_a.state !== 3'd1 || if_a.match_count !== 8'd0) begin
         errors++;
         $display("FAIL reset_mid: got det=%0d state=%0d cnt=%0d want 0/1/0",
                  det_cnt, if_a.state, if_a.match_count);
      end
   endtask

   task automatic test_pulse_at_release();
      do_reset(1'b1, 1'b1);
      clear_obs();
      repeat (4) step(1'b1, 1'b1);
      repeat (2) step(1'b0, 1'b0);
      vectors++;
      if (nv !== 1) begin
         errors++; $display("FAIL release_strobe: got %0d bit_valids want 1", nv);
      end
   endtask

   task automatic test_saturate();
      logic [15:0] seq = 16'b1011011011011011;
      do_reset(1'b0, 1'b0);
      clear_obs();
      for (int i = 15; i >= 0; i--) press(seq[i], 1, 1);
      vectors++;
      if (det_cnt !== 5 || if_b.match_count !== 2'd3 || if_a.match_count !== 8'd5) begin
         errors++;
         $display("FAIL saturate: got det=%0d cnt2=%0d cnt8=%0d want 5/3/5",
                  det_cnt, if_b.match_count, if_a.match_count);
      end
   endtask

   task automatic test_led();
      logic [3:0] seq = 4'b1011;
      int low_seen = 0;
      do_reset(1'b0, 1'b0);
      clear_obs();
      for (int i = 3; i >= 0; i--) press(seq[i], 2, 1);
      vectors++;
      if (if_a.detect_led !== 1'b1) begin
         errors++; $display("FAIL led_set: got %b want 1", if_a.detect_led);
      end
      press(1'b0, 2, 1);
      vectors++;
      if (if_a.detect_led !== 1'b0) begin
         errors++; $display("FAIL led_clear: got %b want 0", if_a.detect_led);
      end
      press(1'b1, 2, 1);
      press(1'b1, 2, 1);
      for (int c = 0; c < 20; c++) begin
         step(1'b0, 1'b0);
         if (if_a.detect_led !== 1'b1) low_seen++;
      end
      vectors++;
      if (low_seen !== 0) begin
         errors++; $display("FAIL led_hold: got %0d low clocks want 0", low_seen);
      end
   endtask

   task automatic test_random();
      do_reset(1'b0, 1'b0);
      clear_obs();
      for (int n = 0; n < 300; n++) begin
         // Bias toward 1s so the pattern shows up often enough to exercise overlap.
         press(1'($urandom_range(0, 9) < 6), int'($urandom_range(1, 4)), int'($urandom_range(1, 3)));
         if ($urandom_range(0, 99) == 0) do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      vectors++;
      if (det_cnt == 0) begin
         errors++; $display("FAIL random_coverage: got %0d detects want >0", det_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_overlap();
      test_fallback();
      test_hold();
      test_reset_mid();
      test_pulse_at_release();
      test_saturate();
      test_led();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
